// File: rtl/seq_logic_pkg.sv
// Shared types, limits and parameter-legality helpers for the input-conditioning blocks.
package seq_logic_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_t;

  localparam int MIN_STABLE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MAX_SYNC_STAGES   = 4;

  function automatic bit sync_stages_ok(input int stages);
    return (stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES);
  endfunction

  function automatic bit stable_cycles_ok(input int cycles);
    return cycles >= MIN_STABLE_CYCLES;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer: d is shifted through SYNC_STAGES flops; q is the last stage.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes din and only changes q after STABLE_CYCLES consecutive samples of the new level.
// Optional rise/fall edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_sync
  import seq_logic_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES out of range");
  end
  if (!stable_cycles_ok(STABLE_CYCLES)) begin : g_bad_stable_cycles
    $error("debounce_sync: STABLE_CYCLES below minimum");
  end

  logic             s_in;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_nxt;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
    end
  end

  // Any return of s_in to q restarts qualification from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    case (state)
      STABLE: begin
        if (s_in != q) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (s_in == q) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          q_nxt     = ~q;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == COUNT);

`ifdef DEBOUNCE_EDGE_EN
  // Pulses land in the same cycle q takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= q_nxt & ~q;
      fall <= ~q_nxt & q;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed scenarios with a queue scoreboard; a monitor checks every DUT output after each edge.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic q, busy, rise, fall;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .q   (q),
    .busy(busy),
    .rise(rise),
    .fall(fall)
  );

  typedef struct {
    int    cyc;
    string name;
    int    edge_no;
    logic  q;
    logic  busy;
    logic  rise;
    logic  fall;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: after every edge, check all expectations due on this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        tests++;
        if (q !== e.q || busy !== e.busy || rise !== e.rise || fall !== e.fall) begin
          fails++;
          $display("FAIL %s edge %0d: got q=%b busy=%b rise=%b fall=%b, expected q=%b busy=%b rise=%b fall=%b",
                   e.name, e.edge_no, q, busy, rise, fall, e.q, e.busy, e.rise, e.fall);
        end
      end
    end
  end

  // Bit i of each vector applies to edge i+1 of the scenario.
  task automatic run_seq(input string name, input int n,
                         input logic [31:0] dv, input logic [31:0] rv,
                         input logic [31:0] qv, input logic [31:0] bv,
                         input logic [31:0] risev, input logic [31:0] fallv);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din       = dv[i];
      rst       = rv[i];
      e.cyc     = cyc + 1;
      e.name    = name;
      e.edge_no = i + 1;
      e.q       = qv[i];
      e.busy    = bv[i];
`ifdef DEBOUNCE_EDGE_EN
      e.rise    = risev[i];
      e.fall    = fallv[i];
`else
      e.rise    = 1'b0;
      e.fall    = 1'b0;
`endif
      sb.push_back(e);
    end
  endtask

  initial begin
    //       name          n   din       rst     q         busy      rise      fall
    run_seq("reset",       6, 32'h0007, 32'h7, 32'h0000, 32'h0000, 32'h0000, 32'h0000);
    run_seq("clean_rise",  8, 32'h00FF, 32'h0, 32'h00E0, 32'h001C, 32'h0020, 32'h0000);
    run_seq("clean_fall",  8, 32'h0000, 32'h0, 32'h001F, 32'h001C, 32'h0000, 32'h0020);
    run_seq("glitch3",    10, 32'h0007, 32'h0, 32'h0000, 32'h001C, 32'h0000, 32'h0000);
    run_seq("glitch4",    12, 32'h000F, 32'h0, 32'h01E0, 32'h01DC, 32'h0020, 32'h0200);
    run_seq("bounce",     16, 32'hFF33, 32'h0, 32'hE000, 32'h1CCC, 32'h2000, 32'h0000);
    run_seq("fall_prep",   8, 32'h0000, 32'h0, 32'h001F, 32'h001C, 32'h0000, 32'h0020);
    run_seq("rst_mid",    12, 32'h0FFF, 32'h8, 32'h0E00, 32'h01C4, 32'h0200, 32'h0000);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
